// File: rtl/utils_mul_cla_pipe_pkg.sv
// rtl/utils_mul_cla_pipe_pkg.sv - shared defaults, mode encoding and stage-count helper for the pipelined CLA adder
package utils_mul_cla_pipe_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_GROUP = 8;

    typedef enum logic {
        MUL_ADD = 1'b0,
        MUL_SUB = 1'b1
    } mul_mode_e;

    function automatic int ngrp(input int width, input int group);
        return width / group;
    endfunction

endpackage

// File: rtl/utils_mul_cla_grp.sv
// rtl/utils_mul_cla_grp.sv - combinational GROUP-bit carry-lookahead slice
module utils_mul_cla_grp
    import utils_mul_cla_pipe_pkg::*;
#(
    parameter int GROUP = DEF_GROUP
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             ci,
    output logic [GROUP-1:0] sum,
    output logic             c_msb,
    output logic             gx,
    output logic             px
);

    logic [GROUP-1:0] g;
    logic [GROUP-1:0] p;
    logic [GROUP-1:0] c;

    // Per-bit generate/propagate, internal carries, and the group-level G/P terms
    always_comb begin
        g = a & b;
        p = a ^ b;
        c = '0;
        c[0] = ci;
        for (int i = 1; i < GROUP; i++) begin
            c[i] = g[i-1] | (p[i-1] & c[i-1]);
        end
        sum   = p ^ c;
        // Carry into the slice MSB; the top stage needs it for signed overflow
        c_msb = c[GROUP-1];
        gx = 1'b0;
        for (int i = 0; i < GROUP; i++) begin
            gx = g[i] | (p[i] & gx);
        end
        px = &p;
    end

endmodule

// File: rtl/utils_mul_cla_pipe.sv
// rtl/utils_mul_cla_pipe.sv - pipelined carry-lookahead adder/subtractor, one group per stage
module utils_mul_cla_pipe
    import utils_mul_cla_pipe_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int GROUP = DEF_GROUP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic             in_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_co,
    output logic             out_ovf
);

    localparam int NGRP = ngrp(WIDTH, GROUP);

    if ((WIDTH % GROUP) != 0) begin : g_bad_params
        $error("utils_mul_cla_pipe: WIDTH must be a multiple of GROUP");
    end

    // Stage inputs: stage 0 sees the ports, stage k sees the registers of stage k-1.
    // Raw operand words are shifted down one group per stage so every stage works on bits [GROUP-1:0];
    // finished sum groups enter at the top and drift down until group 0 lands at bit 0.
    logic [WIDTH-1:0] a_src [NGRP];
    logic [WIDTH-1:0] b_src [NGRP];
    logic [WIDTH-1:0] s_src [NGRP];
    logic             c_src [NGRP];
    logic             v_src [NGRP];

    logic [WIDTH-1:0] a_q [NGRP];
    logic [WIDTH-1:0] b_q [NGRP];
    logic [WIDTH-1:0] s_q [NGRP];
    logic             c_q [NGRP];
    logic             v_q [NGRP];

    logic [GROUP-1:0] gsum  [NGRP];
    logic             gcmsb [NGRP];
    logic             ggx   [NGRP];
    logic             gpx   [NGRP];
    logic             gco   [NGRP];

    logic en;
    logic co_q;
    logic ovf_q;
    logic is_sub;

    // One shared advance for the whole pipe: nothing moves while the output beat is blocked
    assign en       = !out_valid || out_ready;
    assign in_ready = en;

    // Subtract is folded in at the entry: invert B and force the carry into group 0
    assign is_sub   = (mul_mode_e'(in_sub) == MUL_SUB);
    assign a_src[0] = in_a;
    assign b_src[0] = is_sub ? ~in_b : in_b;
    assign c_src[0] = is_sub ? 1'b1 : in_ci;
    assign s_src[0] = '0;
    assign v_src[0] = in_valid;

    for (genvar k = 0; k < NGRP; k++) begin : g_stage
        if (k > 0) begin : g_link
            assign a_src[k] = a_q[k-1];
            assign b_src[k] = b_q[k-1];
            assign s_src[k] = s_q[k-1];
            assign c_src[k] = c_q[k-1];
            assign v_src[k] = v_q[k-1];
        end

        utils_mul_cla_grp #(
            .GROUP (GROUP)
        ) u_grp (
            .a     (a_src[k][GROUP-1:0]),
            .b     (b_src[k][GROUP-1:0]),
            .ci    (c_src[k]),
            .sum   (gsum[k]),
            .c_msb (gcmsb[k]),
            .gx    (ggx[k]),
            .px    (gpx[k])
        );

        assign gco[k] = ggx[k] | (gpx[k] & c_src[k]);

        // Stage register: resolve this group, pass the rest along, carry out feeds the next stage
        always_ff @(posedge clk) begin
            if (rst) begin
                v_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
                c_q[k] <= 1'b0;
            end else if (en) begin
                v_q[k] <= v_src[k];
                a_q[k] <= a_src[k] >> GROUP;
                b_q[k] <= b_src[k] >> GROUP;
                s_q[k] <= (s_src[k] >> GROUP) | (WIDTH'(gsum[k]) << (WIDTH - GROUP));
                c_q[k] <= gco[k];
            end
        end
    end

    // Carry-out and signed overflow come from the top group, captured alongside the final sum
    always_ff @(posedge clk) begin
        if (rst) begin
            co_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else if (en) begin
            co_q  <= gco[NGRP-1];
            ovf_q <= gco[NGRP-1] ^ gcmsb[NGRP-1];
        end
    end

    assign out_valid = v_q[NGRP-1];
    assign out_sum   = s_q[NGRP-1];
    assign out_co    = co_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_utils_mul_cla_pipe.sv
// tb/tb_utils_mul_cla_pipe.sv - self-checking bench for utils_mul_cla_pipe
module tb_utils_mul_cla_pipe;

    localparam int W = 32;
    localparam int G = 8;
    localparam int N = W / G;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         in_ci = 1'b0;
    logic         in_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] out_sum;
    logic         out_co;
    logic         out_ovf;

    int errors = 0;
    int checks = 0;
    int ready_mode = 0;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
    } res_t;

    res_t exp_q[$];
    res_t held;
    logic held_v = 1'b0;

    always #5 clk = ~clk;

    utils_mul_cla_pipe #(
        .WIDTH (W),
        .GROUP (G)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_ci     (in_ci),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_co    (out_co),
        .out_ovf   (out_ovf)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sub);
        res_t r;
        logic [W:0] full;
        if (sub) begin
            full  = {1'b0, a} - {1'b0, b};
            r.sum = full[W-1:0];
            r.co  = (a >= b);
            r.ovf = (a[W-1] != b[W-1]) && (r.sum[W-1] != a[W-1]);
        end else begin
            full  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.sum = full[W-1:0];
            r.co  = full[W];
            r.ovf = (a[W-1] == b[W-1]) && (r.sum[W-1] != a[W-1]);
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Output-ready driver: 0 = always ready, 1 = random, 2 = held off
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ($urandom_range(0, 3) != 0);
            default: out_ready = 1'b0;
        endcase
    end

    // Scoreboard: push on accepted input, compare and pop on presented output, check stall behaviour
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            held_v = 1'b0;
        end else begin
            check("in_ready", 64'(in_ready), 64'(!out_valid || out_ready));
            if (held_v) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'({out_sum, out_co, out_ovf}), 64'(held));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious: got beat %h expected no beat at %0t", out_sum, $time);
                end else begin
                    check("stream", 64'({out_sum, out_co, out_ovf}), 64'(exp_q[0]));
                    if (out_ready) void'(exp_q.pop_front());
                end
            end
            held_v = out_valid && !out_ready;
            held   = {out_sum, out_co, out_ovf};
            if (in_valid && in_ready) exp_q.push_back(model(in_a, in_b, in_ci, in_sub));
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the beat was taken
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci, input logic sub);
        int n = 0;
        in_a = a; in_b = b; in_ci = ci; in_sub = sub; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("send_timeout", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic directed(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic ci, input logic sub,
                            input logic [W-1:0] es, input logic eco, input logic eovf);
        res_t m;
        int lat;
        m = model(a, b, ci, sub);
        check({name, "_model"}, 64'({m.sum, m.co, m.ovf}), 64'({es, eco, eovf}));
        send(a, b, ci, sub);
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(N));
        check({name, "_dut"}, 64'({out_sum, out_co, out_ovf}), 64'({es, eco, eovf}));
    endtask

    task automatic drain(input string name);
        int n = 0;
        ready_mode = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({name, "_drained"}, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int seen;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_sum", 64'(out_sum), 64'd0);
        check("reset_out_flags", 64'({out_co, out_ovf}), 64'd0);
        check("reset_in_ready", 64'(in_ready), 64'd1);

        directed("add_ff_1",   32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0100, 1'b0, 1'b0);
        directed("ripple_ci",  32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("signed_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1);
        directed("sub_5_7",    32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0);
        directed("sub_ovf",    32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1);
        directed("wrap",       32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0);
        directed("sub_ci_ign", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 32'h0000_0007, 1'b1, 1'b0);
        drain("directed");

        // Ten back-to-back beats with the output held off for four cycles mid-stream
        fork
            begin
                for (int i = 0; i < 10; i++) send(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            begin
                repeat (5) @(posedge clk);
                ready_mode = 2;
                @(posedge clk);
                #1;
                check("bp_in_ready_low", 64'(in_ready), 64'd0);
                repeat (3) @(posedge clk);
                ready_mode = 0;
            end
        join
        drain("backpressure");

        // Reset with three beats in flight: nothing from them may ever appear
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
        send(32'h3333_3333, 32'h4444_4444, 1'b1, 1'b0);
        send(32'h5555_5555, 32'h0000_0001, 1'b0, 1'b1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 64'(seen), 64'd0);

        // Random operands, random gaps, random output ready
        ready_mode = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            send(rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        drain("random");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no finish expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
